avalon_pio_in_edge: RTL and testbench



---
 rtl/avalon_pio_in_edge_pkg.sv | 26 ++
 rtl/avalon_pio_in_edge_if.sv | 29 ++
 rtl/avalon_pio_in_edge_chan.sv | 92 +++++++++
 rtl/avalon_pio_in_edge.sv | 91 +++++++++
 tb/tb_avalon_pio_in_edge.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_pio_in_edge_pkg.sv
// Shared constants for the game-controller input PIO: register offsets,
// edge-select encodings and a width helper.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/avalon_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the input PIO (single-cycle, fixed read latency).
interface avalon_pio_in_edge_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_pio_in_edge_chan.sv
// One input channel: metastability synchroniser, optional debounce filter and
// edge detector reporting the edge on the same clock edge the stable value moves.
module pio_in_chan
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic stable_o,
    output logic edge_pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable_q;
    logic                   stable_d;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_filter
            assign stable_d = sync;
        end else begin : g_filter
            localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Counter tracks how long sync has disagreed with stable; any
            // return to agreement throws the partial count away.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = sync;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable_d;
        end
    end

    // Edge is taken from the next-state value so capture lands with the update.
    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    always_comb begin
        edge_pulse_o = 1'b0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_pulse_o = rise;
            EDGE_FALLING: edge_pulse_o = fall;
            default:      edge_pulse_o = rise | fall;
        endcase
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM input PIO: per-channel filtered inputs, W1C edge capture with
// interrupt mask, and a registered read mux.
module avalon_pio_in_edge
    import pio_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_pio_in_edge_if.slave   bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_pulse;

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;
    logic             unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            pio_in_chan #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .EDGE_TYPE       (EDGE_TYPE)
            ) u_chan (
                .clk          (clk),
                .reset_n      (reset_n),
                .din_i        (in_port[gi]),
                .stable_o     (stable[gi]),
                .edge_pulse_o (edge_pulse[gi])
            );
        end
    endgenerate

    assign wr_en = bus.chipselect & bus.write;

    always_comb begin
        mask_d = mask_q;
        w1c    = '0;
        if (wr_en && bus.address == ADDR_MASK) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == ADDR_EDGE) begin
            w1c = bus.writedata[WIDTH-1:0];
        end
        // New edges are OR'd in after the clear, so a coincident set wins.
        edge_capture_d = (edge_capture_q & ~w1c) | edge_pulse;
    end

    // Read data is refreshed every cycle regardless of the read strobe.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA: readdata_d = 32'(stable);
            ADDR_MASK: readdata_d = 32'(mask_q);
            ADDR_EDGE: readdata_d = 32'(edge_capture_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q         <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            mask_q         <= mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edge_capture_q & mask_q);

    assign unused_bits = &{1'b0, bus.read, bus.writedata};

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Scoreboard bench: dut0 is unfiltered rising-edge, dut1 has a 4-cycle
// debounce and captures any edge. Reads push expectations; monitors compare.
module tb_avalon_pio_in_edge;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_RSVD = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_EDGE = 2'd3;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    logic       clk;
    logic       reset_n_a;
    logic       reset_n_b;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       irq0;
    logic       irq1;
    logic       rdp0 = 1'b0;
    logic       rdp1 = 1'b0;

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];

    avalon_pio_in_edge_if bus0 ();
    avalon_pio_in_edge_if bus1 ();

    avalon_pio_in_edge #(
        .WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n_a),
        .bus     (bus0),
        .in_port (in_a),
        .irq     (irq0)
    );

    avalon_pio_in_edge #(
        .WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n_b),
        .bus     (bus1),
        .in_port (in_b),
        .irq     (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    task automatic chk(input int d, input logic [31:0] rdata, input logic irqv);
        exp_t e;
        total++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_read dut%0d: readdata=%h with no expectation", d, rdata);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (rdata !== e.data || irqv !== e.irq) begin
            bad++;
            $display("FAIL %s dut%0d: got readdata=%h irq=%b, expected readdata=%h irq=%b",
                     e.name, d, rdata, irqv, e.data, e.irq);
        end else begin
            $display("ok   %s dut%0d: readdata=%h irq=%b", e.name, d, rdata, irqv);
        end
    endtask

    always @(posedge clk) begin
        rdp0 <= bus0.chipselect & bus0.read;
        rdp1 <= bus1.chipselect & bus1.read;
    end

    always @(negedge clk) begin
        if (rdp0) chk(0, bus0.readdata, irq0);
        if (rdp1) chk(1, bus1.readdata, irq1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int d, input logic cs, input logic rd_s, input logic wr_s,
                         input logic [1:0] a, input logic [31:0] wd);
        if (d == 0) begin
            bus0.chipselect = cs; bus0.read = rd_s; bus0.write = wr_s;
            bus0.address = a; bus0.writedata = wd;
        end else begin
            bus1.chipselect = cs; bus1.read = rd_s; bus1.write = wr_s;
            bus1.address = a; bus1.writedata = wd;
        end
    endtask

    task automatic step(input int d);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) step(d);
    endtask

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] ed,
                      input logic ei, input string nm);
        exp_t e;
        e.name = nm; e.data = ed; e.irq = ei;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        drive(d, 1'b1, 1'b1, 1'b0, a, 32'd0);
        step(d);
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] wd);
        $display("wr   dut%0d addr=%0d data=%h", d, a, wd);
        drive(d, 1'b1, 1'b0, 1'b1, a, wd);
        step(d);
    endtask

    task automatic direct(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end else begin
            $display("ok   %s: %h", nm, got);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        in_a = 3'b000;
        in_b = 3'b000;
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n_a = 1'b1;
        reset_n_b = 1'b1;

        // Reset state
        rd(0, A_DATA, 32'h0, 1'b0, "rst_data");
        rd(0, A_MASK, 32'h0, 1'b0, "rst_mask");
        rd(0, A_EDGE, 32'h0, 1'b0, "rst_edge");
        rd(1, A_EDGE, 32'h0, 1'b0, "rst_edge_b");

        // Latency: change visible in readdata exactly 4 edges after drive
        in_a = 3'b101;
        rd(0, A_DATA, 32'h0, 1'b0, "lat_e1");
        rd(0, A_DATA, 32'h0, 1'b0, "lat_e2");
        rd(0, A_DATA, 32'h0, 1'b0, "lat_e3");
        rd(0, A_DATA, 32'h5, 1'b0, "lat_e4");
        rd(0, A_EDGE, 32'h5, 1'b0, "lat_capture");

        // Rising-only capture, W1C and irq masking
        wr(0, A_EDGE, 32'h7);
        rd(0, A_EDGE, 32'h0, 1'b0, "t3_cleared");
        wr(0, A_MASK, 32'h4);
        rd(0, A_MASK, 32'h4, 1'b0, "t3_mask");
        in_a = 3'b001;
        idle(0, 4);
        rd(0, A_EDGE, 32'h0, 1'b0, "t3_fall_nocap");
        in_a = 3'b101;
        idle(0, 4);
        rd(0, A_EDGE, 32'h4, 1'b1, "t3_rise_irq");
        wr(0, A_EDGE, 32'h4);
        rd(0, A_EDGE, 32'h0, 1'b0, "t3_w1c");
        in_a = 3'b001;
        idle(0, 4);
        rd(0, A_EDGE, 32'h0, 1'b0, "t3_fall_after");

        // Masked capture, late unmask, writes to read-only/reserved words
        wr(0, A_MASK, 32'h0);
        in_a = 3'b000;
        idle(0, 4);
        wr(0, A_EDGE, 32'h7);
        in_a = 3'b001;
        idle(0, 4);
        rd(0, A_EDGE, 32'h1, 1'b0, "t5_masked_cap");
        wr(0, A_MASK, 32'h1);
        rd(0, A_MASK, 32'h1, 1'b1, "t5_unmask_irq");
        wr(0, A_DATA, 32'hFFFF_FFFF);
        wr(0, A_RSVD, 32'hFFFF_FFFF);
        rd(0, A_DATA, 32'h1, 1'b1, "t5_data_kept");
        rd(0, A_RSVD, 32'h0, 1'b1, "t5_rsvd_zero");
        rd(0, A_MASK, 32'h1, 1'b1, "t5_mask_kept");
        rd(0, A_EDGE, 32'h1, 1'b1, "t5_edge_kept");

        // Debounce: 3-cycle glitch rejected
        in_b = 3'b010;
        idle(1, 3);
        in_b = 3'b000;
        idle(1, 8);
        rd(1, A_DATA, 32'h0, 1'b0, "t2_glitch_data");
        rd(1, A_EDGE, 32'h0, 1'b0, "t2_glitch_edge");

        // Debounce: steady level accepted after 2+4 edges, readdata one later
        in_b = 3'b010;
        for (int i = 1; i <= 6; i++) begin
            rd(1, A_DATA, 32'h0, 1'b0, $sformatf("t2_level_e%0d", i));
        end
        rd(1, A_DATA, 32'h2, 1'b0, "t2_level_e7");
        rd(1, A_EDGE, 32'h2, 1'b0, "t2_level_edge");

        // Any-edge capture and set-wins-over-clear
        wr(1, A_EDGE, 32'h7);
        rd(1, A_EDGE, 32'h0, 1'b0, "t4_cleared");
        in_b = 3'b011;
        idle(1, 8);
        rd(1, A_EDGE, 32'h1, 1'b0, "t4_rise_cap");
        wr(1, A_EDGE, 32'h1);
        rd(1, A_EDGE, 32'h0, 1'b0, "t4_w1c");
        in_b = 3'b010;
        idle(1, 5);
        wr(1, A_EDGE, 32'h1);
        rd(1, A_EDGE, 32'h1, 1'b0, "t4_set_wins");
        rd(1, A_DATA, 32'h2, 1'b0, "t4_data");

        // Build capture=011 with irq enabled, then reset mid-debounce
        wr(1, A_EDGE, 32'h7);
        rd(1, A_EDGE, 32'h0, 1'b0, "t6_cleared");
        in_b = 3'b000;
        idle(1, 8);
        in_b = 3'b001;
        idle(1, 8);
        rd(1, A_EDGE, 32'h3, 1'b0, "t6_capture");
        rd(1, A_DATA, 32'h1, 1'b0, "t6_data");
        wr(1, A_MASK, 32'h3);
        rd(1, A_MASK, 32'h3, 1'b1, "t6_irq_on");
        in_b = 3'b101;
        idle(1, 4);
        reset_n_b = 1'b0;
        #2;
        direct("t6_async_readdata", bus1.readdata, 32'h0);
        direct("t6_async_irq", {31'd0, irq1}, 32'h0);
        @(posedge clk);
        #1;
        reset_n_b = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            rd(1, A_DATA, 32'h0, 1'b0, $sformatf("t6_requal_e%0d", i));
        end
        rd(1, A_DATA, 32'h5, 1'b0, "t6_requal_e7");
        rd(1, A_EDGE, 32'h5, 1'b0, "t6_edge_after");
        rd(1, A_MASK, 32'h0, 1'b0, "t6_mask_reset");

        idle(0, 3);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0",
                     q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
